// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//
// Multi-cycle multiply/divide unit with the architectural HI/LO registers for
// the execute stage. MULT/MULTU finish after a fixed MUL_CYCLES latency.
// DIV/DIVU run WIDTH restoring radix-2 iterations followed by one sign-fixup
// cycle. MTHI/MTLO writes and a pipeline-flush cancel are supported.
//
// Handshake: an operation is accepted on a rising edge where
// start & ready & !cancel. ready is high in IDLE and DONE only. A start seen
// while ready=0 is dropped; nothing is queued. out_valid is a one-cycle pulse
// (the DONE state). hi/lo are loaded on the edge that enters DONE, so they
// already hold the new result during the out_valid cycle.
//
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   start, op, a, b    operation request (op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   cancel             flush; aborts an operation in flight
//   wr_hi, wr_lo, wdata  MTHI/MTLO writes, honoured only while ready=1
//   ready, busy        ready for start / operation in flight
//   out_valid          one-cycle result pulse
//   hi, lo             architectural HI/LO registers
//   state_dbg          current FSM state encoding (IDLE=0, MUL=1, DIV=2, DONE=3)
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             ready,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       state_dbg
);

  localparam int CNT_MAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Operand / control registers
  logic [CNT_W-1:0] cnt_q;      // multiply latency or divide iteration counter
  logic             fixup_q;    // divide iterations finished, sign-fixup pending
  logic             signed_q;   // MULT/DIV (signed) vs MULTU/DIVU
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  // Divider datapath
  logic [WIDTH-1:0] rem_q;      // partial remainder (magnitude)
  logic [WIDTH-1:0] quo_q;      // dividend shifted out / quotient shifted in
  logic [WIDTH-1:0] dvs_q;      // divisor magnitude
  logic             q_neg_q;
  logic             r_neg_q;

  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  // ---------------------------------------------------------------------------
  // Acceptance
  // ---------------------------------------------------------------------------
  logic ready_int;
  logic accept;

  assign ready_int = (state_q == S_IDLE) || (state_q == S_DONE);
  assign accept    = start && ready_int && !cancel;

  // Operand magnitudes for the divider, taken from the live inputs at accept.
  logic             op_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign op_signed = ~op[0];
  assign a_neg     = op_signed & a[WIDTH-1];
  assign b_neg     = op_signed & b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

  // ---------------------------------------------------------------------------
  // Multiplier: operands extended to 2*WIDTH so one unsigned multiply serves
  // both signed and unsigned forms (two's complement modulo 2^(2W)).
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] mul_a;
  logic [2*WIDTH-1:0] mul_b;
  logic [2*WIDTH-1:0] product;

  assign mul_a   = {{WIDTH{signed_q & a_q[WIDTH-1]}}, a_q};
  assign mul_b   = {{WIDTH{signed_q & b_q[WIDTH-1]}}, b_q};
  assign product = mul_a * mul_b;

  // ---------------------------------------------------------------------------
  // Restoring divide step. The remainder stays below the divisor, so it fits in
  // WIDTH bits once the trial subtraction has been resolved.
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   diff;
  logic             trial_ok;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;

  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign diff      = rem_shift - {1'b0, dvs_q};
  assign trial_ok  = rem_shift >= {1'b0, dvs_q};
  assign rem_step  = WIDTH'(trial_ok ? diff : rem_shift);
  assign quo_step  = {quo_q[WIDTH-2:0], trial_ok};

  // Sign fixup. Divide by zero leaves an all-ones quotient and the original
  // dividend in HI. The -2^(W-1) / -1 overflow needs no special case: the
  // magnitude quotient is 2^(W-1) and both signs cancel, giving -2^(W-1), rem 0.
  logic             div_zero;
  logic [WIDTH-1:0] div_lo;
  logic [WIDTH-1:0] div_hi;

  assign div_zero = (dvs_q == '0);
  assign div_lo   = div_zero ? '1  : (q_neg_q ? -quo_q : quo_q);
  assign div_hi   = div_zero ? a_q : (r_neg_q ? -rem_q : rem_q);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state and status outputs
  always_comb begin
    state_d   = state_q;
    ready     = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (accept) state_d = op[1] ? S_DIV : S_MUL;
      end
      S_MUL: begin
        busy = 1'b1;
        if (cancel)              state_d = S_IDLE;
        else if (cnt_q == '0)    state_d = S_DONE;
      end
      S_DIV: begin
        busy = 1'b1;
        if (cancel)              state_d = S_IDLE;
        else if (fixup_q)        state_d = S_DONE;
      end
      S_DONE: begin
        ready     = 1'b1;
        out_valid = 1'b1;
        if (accept) state_d = op[1] ? S_DIV : S_MUL;
        else        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and HI/LO registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q    <= '0;
      fixup_q  <= 1'b0;
      signed_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      if (accept) begin
        signed_q <= op_signed;
        a_q      <= a;
        b_q      <= b;
        cnt_q    <= op[1] ? DIV_LOAD : MUL_LOAD;
        fixup_q  <= 1'b0;
        rem_q    <= '0;
        quo_q    <= a_mag;
        dvs_q    <= b_mag;
        q_neg_q  <= a_neg ^ b_neg;
        r_neg_q  <= a_neg;
      end else if (state_q == S_MUL && !cancel) begin
        if (cnt_q == '0) begin
          hi_q <= product[2*WIDTH-1:WIDTH];
          lo_q <= product[WIDTH-1:0];
        end else begin
          cnt_q <= cnt_q - CNT_ONE;
        end
      end else if (state_q == S_DIV && !cancel) begin
        if (fixup_q) begin
          hi_q <= div_hi;
          lo_q <= div_lo;
        end else begin
          rem_q <= rem_step;
          quo_q <= quo_step;
          if (cnt_q == '0) fixup_q <= 1'b1;
          else             cnt_q   <= cnt_q - CNT_ONE;
        end
      end

      // MTHI/MTLO only while ready; commits only happen from MUL/DIV, so the
      // two never collide.
      if (ready_int && wr_hi) hi_q <= wdata;
      if (ready_int && wr_lo) lo_q <= wdata;
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  localparam int W  = 32;
  localparam int MC = 2;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         resetn;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cancel;
  logic         wr_hi;
  logic         wr_lo;
  logic [W-1:0] wdata;
  logic         ready;
  logic         busy;
  logic         out_valid;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [1:0]   state_dbg;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  muldiv_unit #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
    .ready(ready), .busy(busy), .out_valid(out_valid), .hi(hi), .lo(lo),
    .state_dbg(state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [2*W-1:0] exp_q[$];
  int             exp_cyc_q[$];
  string          exp_name_q[$];

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every out_valid pulse must match the oldest expected result and
  // arrive on the expected cycle.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid actual hi=%h lo=%h required no pulse (cycle %0d)", hi, lo, cyc);
      end else begin
        logic [2*W-1:0] e;
        int             c;
        string          n;
        e = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        n = exp_name_q.pop_front();
        check({n, "_result"}, {hi, lo}, e);
        check({n, "_latency"}, 64'(cyc), 64'(c));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called at a negedge with ready=1; return at the next negedge)
  // ---------------------------------------------------------------------------
  task automatic issue(input string nm, input logic [1:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [W-1:0] eh,
                       input logic [W-1:0] el, input bit expect_result);
    int lat;
    lat   = o[1] ? (W + 1) : MC;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    if (expect_result) begin
      exp_q.push_back({eh, el});
      exp_cyc_q.push_back(cyc + 1 + lat);
      exp_name_q.push_back(nm);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual pending=%0d required 0", exp_q.size());
      exp_q.delete();
      exp_cyc_q.delete();
      exp_name_q.delete();
    end
  endtask

  task automatic wait_valid(input string nm, input int max_cycles);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    if (out_valid !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual out_valid=%b required 1", nm, out_valid);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    resetn = 1'b0;
    start  = 1'b0;
    op     = 2'b00;
    a      = '0;
    b      = '0;
    cancel = 1'b0;
    wr_hi  = 1'b0;
    wr_lo  = 1'b0;
    wdata  = '0;

    #3;
    check("reset_hi", 64'(hi), 64'h0);
    check("reset_lo", 64'(lo), 64'h0);
    check("reset_ready", 64'(ready), 64'h1);
    check("reset_busy", 64'(busy), 64'h0);
    check("reset_out_valid", 64'(out_valid), 64'h0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Directed vectors
    issue("mult_neg2x3",  2'b00, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1);
    wait_drain(20);
    issue("multu_neg2x3", 2'b01, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA, 1);
    wait_drain(20);
    issue("div_neg7_2",   2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1);
    wait_drain(60);
    issue("divu_7_2",     2'b11, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1);
    wait_drain(60);
    issue("div_overflow", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1);
    wait_drain(60);
    issue("divu_by_zero", 2'b11, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1);
    wait_drain(60);

    // Cancel 10 cycles into a divide; a start alongside the cancel is ignored
    issue("divu_cancelled", 2'b11, 32'd100, 32'd7, '0, '0, 0);
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    start  = 1'b1;
    op     = 2'b01;
    a      = 32'd9;
    b      = 32'd9;
    @(negedge clk);
    cancel = 1'b0;
    start  = 1'b0;
    check("cancel_busy", 64'(busy), 64'h0);
    check("cancel_ready", 64'(ready), 64'h1);
    check("cancel_hi_kept", 64'(hi), 64'h5);
    check("cancel_lo_kept", 64'(lo), 64'hFFFFFFFF);

    // Cancel in IDLE blocks start but not an MTLO write
    cancel = 1'b1;
    start  = 1'b1;
    wr_lo  = 1'b1;
    wdata  = 32'h00001234;
    @(negedge clk);
    cancel = 1'b0;
    start  = 1'b0;
    wr_lo  = 1'b0;
    check("idle_cancel_busy", 64'(busy), 64'h0);
    check("idle_cancel_mtlo", 64'(lo), 64'h1234);
    check("idle_cancel_hi", 64'(hi), 64'h5);
    @(negedge clk);
    check("idle_cancel_still_idle", 64'(busy), 64'h0);

    // Back-to-back issue from DONE, MTHI while busy and during DONE
    issue("multu_3x4", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1);
    wait_valid("multu_3x4", 10);
    issue("divu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1);
    wr_hi = 1'b1;
    wdata = 32'hA5A5A5A5;
    @(negedge clk);
    wr_hi = 1'b0;
    check("mthi_busy_ignored", 64'(hi), 64'h0);
    check("mthi_busy_state", 64'(busy), 64'h1);
    wait_valid("divu_100_7", 40);
    wr_hi = 1'b1;
    wdata = 32'hA5A5A5A5;
    @(negedge clk);
    wr_hi = 1'b0;
    check("mthi_done_hi", 64'(hi), 64'hA5A5A5A5);
    check("mthi_done_lo", 64'(lo), 64'd14);
    wait_drain(10);

    // Asynchronous reset between edges in the middle of a divide
    issue("div_reset", 2'b10, 32'd100, 32'd7, '0, '0, 0);
    repeat (5) @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("async_reset_hi", 64'(hi), 64'h0);
    check("async_reset_lo", 64'(lo), 64'h0);
    check("async_reset_out_valid", 64'(out_valid), 64'h0);
    check("async_reset_ready", 64'(ready), 64'h1);
    check("async_reset_busy", 64'(busy), 64'h0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    issue("mult_5x6", 2'b00, 32'd5, 32'd6, 32'd0, 32'd30, 1);
    wait_drain(20);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout actual time=%0t required finish earlier", $time);
    $fatal(1, "time limit");
  end

endmodule
